// File: rtl/bus_decoder_if.sv
// bus_decoder_if: bundles the master-side request/response signals and the
// shared slave-side request lines of the address decoder.
//
// Modports:
//   slave  - the decoder itself: takes master requests and slave replies,
//            drives the master response and the per-slave requests.
//   master - the environment around the decoder: the requesting master
//            together with the attached slaves.
//
// Signals:
//   m_req, m_wen, m_addr, m_wdata : master request
//   m_ready, m_ack, m_rdata, m_err: master response
//   s_req (one-hot), s_wen, s_addr, s_wdata : slave request
//   s_ack, s_rdata (packed per slave) : slave reply
interface bus_decoder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int N_SLV  = 2
) ();

  logic                    m_req;
  logic                    m_wen;
  logic [ADDR_W-1:0]       m_addr;
  logic [DATA_W-1:0]       m_wdata;
  logic                    m_ready;
  logic                    m_ack;
  logic [DATA_W-1:0]       m_rdata;
  logic                    m_err;

  logic [N_SLV-1:0]        s_req;
  logic                    s_wen;
  logic [ADDR_W-1:0]       s_addr;
  logic [DATA_W-1:0]       s_wdata;
  logic [N_SLV-1:0]        s_ack;
  logic [N_SLV*DATA_W-1:0] s_rdata;

  modport slave (
    input  m_req, m_wen, m_addr, m_wdata, s_ack, s_rdata,
    output m_ready, m_ack, m_rdata, m_err, s_req, s_wen, s_addr, s_wdata
  );

  modport master (
    output m_req, m_wen, m_addr, m_wdata, s_ack, s_rdata,
    input  m_ready, m_ack, m_rdata, m_err, s_req, s_wen, s_addr, s_wdata
  );

endinterface

// File: rtl/bus_decoder.sv
// bus_decoder: routes a single master request to one of N_SLV slaves by
// base/mask address decode, waits for that slave's ack (bounded by TIMEOUT
// cycles) and returns a one-cycle completion pulse with data and error flag.
// Unmapped addresses and timeouts complete with err=1 and rdata=0.
//
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - bus_decoder_if.slave: master request/response and slave lines
module bus_decoder #(
  parameter int                      ADDR_W   = 16,
  parameter int                      DATA_W   = 32,
  parameter int                      N_SLV    = 2,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {16'hFF00, 16'h0000},
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = {16'hFF00, 16'h0000},
  parameter int                      TIMEOUT  = 15
) (
  input logic          clk,
  input logic          rst_n,
  bus_decoder_if.slave bus
);

  localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state;
  logic [SEL_W-1:0]    sel;
  logic [7:0]          wait_cnt;
  logic                ready_q;
  logic                ack_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [N_SLV-1:0]    sreq_q;
  logic                swen_q;
  logic [ADDR_W-1:0]   saddr_q;
  logic [DATA_W-1:0]   swdata_q;

  logic                hit;
  logic [SEL_W-1:0]    hit_idx;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;

  // Address decode. Scanning from the highest slot down lets the lowest
  // matching index overwrite the others, so overlapping windows resolve to
  // the lowest slave.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((bus.m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  // Only the latched slave's ack and data are looked at; everything else on
  // the slave reply lines is ignored.
  assign sel_ack   = bus.s_ack[sel];
  assign sel_rdata = bus.s_rdata[sel*DATA_W +: DATA_W];

  // Transaction FSM with all outputs registered. wait_cnt counts completed
  // BUSY cycles; reaching TIMEOUT-1 without an ack means this is the last
  // allowed BUSY cycle, so the ack check comes first and wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= '0;
      wait_cnt <= '0;
      ready_q  <= 1'b1;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      sreq_q   <= '0;
      swen_q   <= 1'b0;
      saddr_q  <= '0;
      swdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m_req) begin
            ready_q  <= 1'b0;
            swen_q   <= bus.m_wen;
            saddr_q  <= bus.m_addr;
            swdata_q <= bus.m_wdata;
            sel      <= hit_idx;
            wait_cnt <= '0;
            if (hit) begin
              sreq_q <= N_SLV'(1) << hit_idx;
              state  <= BUSY;
            end else begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              ack_q   <= 1'b1;
              state   <= RESP;
            end
          end
        end
        BUSY: begin
          if (sel_ack) begin
            rdata_q <= swen_q ? '0 : sel_rdata;
            err_q   <= 1'b0;
            sreq_q  <= '0;
            ack_q   <= 1'b1;
            state   <= RESP;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            sreq_q  <= '0;
            ack_q   <= 1'b1;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          sreq_q  <= '0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.m_ready = ready_q;
  assign bus.m_ack   = ack_q;
  assign bus.m_err   = err_q;
  assign bus.m_rdata = rdata_q;
  assign bus.s_req   = sreq_q;
  assign bus.s_wen   = swen_q;
  assign bus.s_addr  = saddr_q;
  assign bus.s_wdata = swdata_q;

endmodule

// File: tb/tb_bus_decoder.sv
// tb_bus_decoder: drives three decoder instances (default map, a narrowed
// slave0 window with a short timeout, and fully overlapping windows) and
// compares every cycle of each transaction with a timeline predicted from
// the address map, ack delay and timeout.
module tb_bus_decoder;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NS = 2;
  localparam int NK = 3;

  localparam logic [31:0] BASE_CFG [NK] = '{32'hFF00_0000, 32'hFF00_0000, 32'h0000_0000};
  localparam logic [31:0] MASK_CFG [NK] = '{32'hFF00_0000, 32'hFF00_F000, 32'h0000_0000};
  localparam int          TO_CFG   [NK] = '{15, 4, 15};

  logic clk;
  logic rst_n;

  logic          mreq   [NK];
  logic          mwen   [NK];
  logic [AW-1:0] maddr  [NK];
  logic [DW-1:0] mwdata [NK];
  logic [NS-1:0] sack   [NK];
  logic [63:0]   srdata [NK];

  logic          oready  [NK];
  logic          oack    [NK];
  logic [DW-1:0] ordata  [NK];
  logic          oerr    [NK];
  logic [NS-1:0] osreq   [NK];
  logic          oswen   [NK];
  logic [AW-1:0] osaddr  [NK];
  logic [DW-1:0] oswdata [NK];

  int checks = 0;
  int errors = 0;

  // Instance 0 keeps every parameter at its default; the others override
  // the address map and timeout.
  for (genvar g = 0; g < NK; g++) begin : gk
    bus_decoder_if #(.ADDR_W(AW), .DATA_W(DW), .N_SLV(NS)) bus ();

    assign bus.m_req   = mreq[g];
    assign bus.m_wen   = mwen[g];
    assign bus.m_addr  = maddr[g];
    assign bus.m_wdata = mwdata[g];
    assign bus.s_ack   = sack[g];
    assign bus.s_rdata = srdata[g];

    assign oready[g]  = bus.m_ready;
    assign oack[g]    = bus.m_ack;
    assign ordata[g]  = bus.m_rdata;
    assign oerr[g]    = bus.m_err;
    assign osreq[g]   = bus.s_req;
    assign oswen[g]   = bus.s_wen;
    assign osaddr[g]  = bus.s_addr;
    assign oswdata[g] = bus.s_wdata;

    if (g == 0) begin : gdef
      bus_decoder u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    end else begin : gcfg
      bus_decoder #(
        .ADDR_W(AW), .DATA_W(DW), .N_SLV(NS),
        .SLV_BASE(BASE_CFG[g]), .SLV_MASK(MASK_CFG[g]), .TIMEOUT(TO_CFG[g])
      ) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] fieldOf(input logic [31:0] word, input int i);
    return word[i*AW +: AW];
  endfunction

  // Reference: the first slot (lowest index) whose masked base equals the
  // masked address; -1 when nothing decodes.
  function automatic int decodeOf(input int k, input logic [AW-1:0] addr);
    logic [AW-1:0] b;
    logic [AW-1:0] m;
    for (int i = 0; i < NS; i++) begin
      b = fieldOf(BASE_CFG[k], i);
      m = fieldOf(MASK_CFG[k], i);
      if ((addr & m) == (b & m)) return i;
    end
    return -1;
  endfunction

  // One transaction on instance k, entered and left on a falling edge with
  // the decoder idle. ackDelay is the cycle (counted from acceptance) in
  // which the selected slave acks; 0 means it never does. spurious keeps the
  // other slave's ack raised throughout.
  task automatic applyStimulus(input int k, input logic wen, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input int ackDelay,
                               input logic [DW-1:0] ackData, input logic spurious);
    int            sel;
    int            respCycle;
    logic          expErr;
    logic [DW-1:0] expRdata;
    logic [NS-1:0] expSreq;
    string         pfx;

    pfx = $sformatf("k%0d a%0h", k, addr);
    sel = decodeOf(k, addr);
    if (sel < 0) begin
      respCycle = 1;
      expErr    = 1'b1;
      expRdata  = '0;
    end else if (ackDelay != 0 && ackDelay <= TO_CFG[k]) begin
      respCycle = ackDelay + 1;
      expErr    = 1'b0;
      expRdata  = wen ? '0 : ackData;
    end else begin
      respCycle = TO_CFG[k] + 1;
      expErr    = 1'b1;
      expRdata  = '0;
    end

    checkOutput({pfx, " ready_idle"}, 64'(oready[k]), 64'd1);
    mreq[k]   = 1'b1;
    mwen[k]   = wen;
    maddr[k]  = addr;
    mwdata[k] = wdata;
    @(posedge clk);

    for (int c = 1; c <= respCycle + 1; c++) begin
      @(negedge clk);
      mreq[k]   = 1'b0;
      mwen[k]   = 1'($urandom);
      maddr[k]  = AW'($urandom);
      mwdata[k] = $urandom;

      expSreq = (sel >= 0 && c < respCycle) ? NS'(1 << sel) : '0;
      checkOutput({pfx, " s_req"}, 64'(osreq[k]), 64'(expSreq));
      checkOutput({pfx, " m_ack"}, 64'(oack[k]), 64'(c == respCycle));
      checkOutput({pfx, " m_ready"}, 64'(oready[k]), 64'(c == respCycle + 1));
      if (c == 1) begin
        checkOutput({pfx, " s_wen"}, 64'(oswen[k]), 64'(wen));
        checkOutput({pfx, " s_addr"}, 64'(osaddr[k]), 64'(addr));
        checkOutput({pfx, " s_wdata"}, 64'(oswdata[k]), 64'(wdata));
      end
      if (c >= respCycle) begin
        checkOutput({pfx, " m_rdata"}, 64'(ordata[k]), 64'(expRdata));
        checkOutput({pfx, " m_err"}, 64'(oerr[k]), 64'(expErr));
      end

      sack[k] = '0;
      if (sel >= 0 && c == ackDelay) sack[k][sel] = 1'b1;
      if (sel >= 0 && spurious) sack[k][1 - sel] = 1'b1;
      srdata[k] = (sel == 1) ? {ackData, ~ackData} : {~ackData, ackData};
    end
    sack[k] = '0;
  endtask

  initial begin
    int            k;
    int            gap;
    logic [AW-1:0] a;

    rst_n = 1'b0;
    for (int i = 0; i < NK; i++) begin
      mreq[i]   = 1'b0;
      mwen[i]   = 1'b0;
      maddr[i]  = '0;
      mwdata[i] = '0;
      sack[i]   = '0;
      srdata[i] = '0;
    end

    #12;
    for (int i = 0; i < NK; i++) begin
      checkOutput($sformatf("rst k%0d m_ready", i), 64'(oready[i]), 64'd1);
      checkOutput($sformatf("rst k%0d m_ack", i), 64'(oack[i]), 64'd0);
      checkOutput($sformatf("rst k%0d m_err", i), 64'(oerr[i]), 64'd0);
      checkOutput($sformatf("rst k%0d m_rdata", i), 64'(ordata[i]), 64'd0);
      checkOutput($sformatf("rst k%0d s_req", i), 64'(osreq[i]), 64'd0);
      checkOutput($sformatf("rst k%0d s_wen", i), 64'(oswen[i]), 64'd0);
      checkOutput($sformatf("rst k%0d s_addr", i), 64'(osaddr[i]), 64'd0);
      checkOutput($sformatf("rst k%0d s_wdata", i), 64'(oswdata[i]), 64'd0);
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases: read with a cycle-2 ack, write to slave1, unmapped
    // access, timeout and ack-on-the-last-cycle, overlap with a spurious ack.
    applyStimulus(0, 1'b0, 16'h0012, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1, 1'b1, 16'hFF04, 32'hCAFE_0001, 1, 32'h1234_5678, 1'b0);
    applyStimulus(1, 1'b0, 16'h8000, 32'h0, 1, 32'h1111_2222, 1'b0);
    applyStimulus(0, 1'b0, 16'h0040, 32'h0, 0, 32'h5555_AAAA, 1'b0);
    applyStimulus(0, 1'b0, 16'h0044, 32'h0, 15, 32'h0BAD_F00D, 1'b0);
    applyStimulus(1, 1'b0, 16'h0ABC, 32'h0, 4, 32'h7777_8888, 1'b0);
    applyStimulus(1, 1'b0, 16'hFF10, 32'h0, 5, 32'h9999_0000, 1'b0);
    applyStimulus(2, 1'b0, 16'hABCD, 32'h0, 3, 32'h0123_4567, 1'b1);
    applyStimulus(0, 1'b0, 16'h2000, 32'h0, 1, 32'h89AB_CDEF, 1'b0);

    // Reset in the middle of a BUSY wait aborts without a completion pulse.
    @(negedge clk);
    mreq[0]  = 1'b1;
    mwen[0]  = 1'b0;
    maddr[0] = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    mreq[0] = 1'b0;
    @(negedge clk);
    checkOutput("midrst busy s_req", 64'(osreq[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst s_req", 64'(osreq[0]), 64'd0);
    checkOutput("midrst m_ready", 64'(oready[0]), 64'd1);
    checkOutput("midrst m_ack", 64'(oack[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("midrst no m_ack", 64'(oack[0]), 64'd0);
    end
    applyStimulus(0, 1'b1, 16'h0300, 32'hFEED_BEEF, 3, 32'h4242_4242, 1'b0);

    // Randomized traffic across all three address maps.
    repeat (60) begin
      k = $urandom_range(0, NK - 1);
      case ($urandom_range(0, 2))
        0:       a = {4'h0, 12'($urandom)};
        1:       a = {8'hFF, 8'($urandom)};
        default: a = AW'($urandom);
      endcase
      applyStimulus(k, 1'($urandom), a, $urandom,
                    $urandom_range(0, TO_CFG[k] + 2), $urandom, 1'($urandom));
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set address width.
REQ-002 Parameter DATA_W, default 32, SHALL set data width.
REQ-003 Parameter N_SLV, default 2, range 1..8, SHALL set slave port count.
REQ-004 Parameter SLV_BASE, default {16'hFF00,16'h0000}, N_SLV×ADDR_W packed, slot i in bits [i*ADDR_W +: ADDR_W], SHALL give the base address per slave.
REQ-005 Parameter SLV_MASK, default {16'hFF00,16'h0000}, packed the same way, SHALL give the compared address bits per slave.
REQ-006 Parameter TIMEOUT, default 15, range 1..255, SHALL set the maximum cycles to wait for a slave ack.
REQ-007 clk  in  1  single clock; all state changes on the rising edge.
REQ-008 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 m_req  in  1  master request; sampled only while m_ready=1.
REQ-010 m_wen  in  1  1=write, 0=read.
REQ-011 m_addr  in  ADDR_W  request address.
REQ-012 m_wdata  in  DATA_W  write data.
REQ-013 m_ready  out  1  block can accept a request.
REQ-014 m_ack  out  1  one-cycle completion pulse.
REQ-015 m_rdata  out  DATA_W  read data, valid with m_ack.
REQ-016 m_err  out  1  error flag, valid with m_ack.
REQ-017 s_req  out  N_SLV  one-hot per-slave request.
REQ-018 s_wen / s_addr / s_wdata  out  1 / ADDR_W / DATA_W  latched request, shared by all slaves.
REQ-019 s_ack  in  N_SLV  per-slave completion.
REQ-020 s_rdata  in  N_SLV×DATA_W  per-slave read data, packed like SLV_BASE.

Function
REQ-021 Slave i SHALL match when (m_addr & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i]).
REQ-022 On overlapping matches the lowest index SHALL win; at most one s_req bit SHALL ever be high.
REQ-023 FSM states SHALL be IDLE, BUSY and RESP.
REQ-024 m_ready SHALL be 1 only in IDLE.
REQ-025 IDLE with m_req=1 (cycle 0), address matched: latch slave index, m_wen, m_addr and m_wdata; go to BUSY; s_req[sel]=1 from cycle 1.
REQ-026 IDLE with m_req=1, no slave matched: go to RESP with err=1 and rdata=0; s_req stays 0.
REQ-027 BUSY: s_req[sel] SHALL stay high until s_ack[sel]=1; s_ack on non-selected slaves SHALL be ignored.
REQ-028 BUSY with s_ack[sel]=1 in cycle k: capture s_rdata[sel] (reads) or 0 (writes) with err=0; s_req low from cycle k+1; go to RESP.
REQ-029 BUSY timeout: the wait counter SHALL clear on entry and increment each BUSY cycle. When it reaches TIMEOUT with no ack, go to RESP with err=1 and rdata=0, and drop s_req.
REQ-030 s_ack[sel] arriving in the same cycle the counter reaches TIMEOUT SHALL complete normally (ack wins).
REQ-031 RESP: m_ack=1 for exactly one cycle with the registered m_rdata and m_err, then return to IDLE.
REQ-032 m_rdata and m_err SHALL hold their last values outside m_ack.
REQ-033 Minimum latency: m_ack 2 cycles after acceptance if the slave acks in cycle 1; unmapped requests ack in cycle 1.
REQ-034 Back-to-back: a new request SHALL be accepted the cycle after m_ack (one IDLE cycle minimum).
REQ-035 s_wen, s_addr and s_wdata SHALL be stable from acceptance until the next acceptance.

Reset
REQ-036 rst_n=0 SHALL immediately force state IDLE and counter 0. Outputs go to m_ready=1, m_ack=0, m_err=0, m_rdata=0, s_req=0, s_wen=0, s_addr=0, s_wdata=0.
REQ-037 Reset asserted mid-transaction SHALL abort it with no m_ack.
REQ-038 After reset release, a request MAY be accepted on the first rising edge.

Verification
REQ-039 Defaults, read at 0x0012, slave0 acks in cycle 2 with 0xDEADBEEF -> s_req=01 in cycles 1-2, m_ack with rdata=0xDEADBEEF and err=0 in cycle 3.
REQ-040 Write at 0xFF04 -> s_req=10, s_wen=1, s_addr=0xFF04; slave1 ack -> m_ack with err=0 and rdata=0.
REQ-041 SLV_MASK slot0=16'hF000, slot1=16'hFF00, SLV_BASE slot0=0x0000, slot1=0xFF00 (slave0 covers 0x0000-0x0FFF), access 0x8000 -> no s_req, m_ack with err=1 in cycle 1.
REQ-042 Slave never acks, TIMEOUT=15 -> s_req drops and m_ack with err=1 follows after 15 BUSY cycles. Also: ack exactly at the timeout cycle -> err=0.
REQ-043 Overlap, both slots base 0x0000 and mask 0x0000 -> only s_req[0] asserts; a spurious s_ack[1] during BUSY is ignored.
REQ-044 rst_n low while in BUSY -> s_req=0 and m_ready=1 at once, no m_ack; the next request completes normally.
